// File: rtl/load_store_unit.sv
// Load/store unit: bridges execute-stage load/store requests to a word-organised
// data memory port, with lane alignment, load extension, and error/timeout reporting.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef enum logic [2:0] {
        F_B  = 3'b000,
        F_H  = 3'b001,
        F_W  = 3'b010,
        F_BU = 3'b100,
        F_HU = 3'b101
    } funct3_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;

    logic          legal;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Legality of the presented access, decided from the live request fields.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            F_B:     legal = 1'b1;
            F_H:     legal = ~req_addr[0];
            F_W:     legal = (req_addr[1:0] == 2'b00);
            F_BU:    legal = ~req_we;
            F_HU:    legal = ~req_we & ~req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_wdata = 32'h0;
        st_be    = 4'b1111;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{req_wdata[7:0]}};
                    st_be    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    st_wdata = {2{req_wdata[15:0]}};
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = req_wdata;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Lane select and extension of the returning word, using the captured request.
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
            F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
            F_BU:    ld_data = {24'h0, ld_byte};
            F_HU:    ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= st_wdata;
                        mem_be    <= st_be;
                        wait_cnt  <= '0;
                        if (legal) begin
                            state   <= BUS;
                            mem_req <= 1'b1;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end
                    end
                end
                BUS: begin
                    // An ack arriving on the final wait cycle still completes normally.
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? 32'h0 : ld_data;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address plus control-unit load/store decode) and a word-organised data memory port.
- Accepts one load or store per handshake and drives a held bus request until the memory acknowledges it.
- Aligns store data and generates byte enables; extracts and sign- or zero-extends load data.
- Flags misaligned or unsupported accesses and bus timeouts as errors. A non-IDLE state signals a pipeline stall.

Parameters:
- TIMEOUT, 16, number of BUS cycles without mem_ack before the access is aborted with an error (minimum 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  execute stage presents an access.
- req_ready  output  1  unit can accept an access (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address from the ALU.
- req_wdata  input  32  rs2 store data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  valid with rsp_valid; misaligned, unsupported or timeout.
- busy  output  1  high whenever state is not IDLE (stall).
- mem_req  output  1  bus request, held until ack or timeout.
- mem_we  output  1  bus write.
- mem_addr  output  32  word address, {req_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-shifted store data.
- mem_be  output  4  byte enables (write lanes).
- mem_ack  input  1  memory completes the access; mem_rdata valid this cycle.
- mem_rdata  input  32  read word.

Behaviour:
- Reset state (async on rst_n low):
  - state = IDLE; all outputs 0 except req_ready = 1.
  - Any in-flight access is dropped and mem_req falls immediately.
  - No response is produced for a dropped access.
- States: IDLE, BUS, RESP.
- IDLE:
  - Handshake when req_valid && req_ready. Register we, funct3, addr[1:0], mem_addr, mem_wdata and mem_be.
  - Legal access → BUS.
  - Illegal access → RESP with err = 1, and no bus activity.
- Illegal accesses:
  - funct3 of 011, 110 or 111.
  - A store with funct3[2] = 1.
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
- BUS:
  - mem_req = 1; mem_we/mem_addr/mem_wdata/mem_be stable until exit.
  - Wait counter starts at 0 on entry and increments on each BUS cycle without ack.
  - mem_ack high → capture and extend the data, go to RESP with err = 0. mem_req is 0 in the next cycle.
  - Counter == TIMEOUT-1 with no ack → RESP with err = 1 and rdata = 0.
  - Ack in the same cycle as the timeout condition: the ack wins.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE. req_ready is 0 during RESP.
- mem_ack is ignored outside BUS.
- Latency:
  - Legal access with ack k cycles after mem_req rises (k ≥ 0): rsp_valid occurs 2+k cycles after the handshake edge.
  - Illegal access: rsp_valid 1 cycle after the handshake.
  - Back-to-back throughput: at best one access per 3 cycles.
- Store lane rules:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 1 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - SW: mem_wdata = wdata, mem_be = 1111.
- Loads:
  - mem_be = 1111, mem_wdata = 0.
  - Select byte rdata[8*addr[1:0] +: 8] or halfword rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- Inputs req_* are don't-care when not handshaking. Changes to them during BUS or RESP have no effect.

Test Plan:
- LB at addr 0x103, mem_rdata = 0x80112233 with immediate ack → mem_addr 0x100, mem_be 1111, rsp_rdata 0xFFFFFF80, err 0; rsp_valid 2 cycles after the handshake.
- LHU at 0x102, rdata 0xBEEF1234, ack delayed 3 cycles → rsp_rdata 0x0000BEEF, rsp_valid 5 cycles after the handshake; busy high throughout.
- SB 0x000000A5 to 0x001 → mem_we 1, mem_be 0010, mem_wdata 0xA5A5A5A5. SH to 0x002 → mem_be 1100. Both give rsp_rdata 0, err 0.
- LW at 0x102 and SH at 0x003 → no mem_req; rsp_valid with err 1 one cycle after the handshake. funct3 = 011 also gives err 1.
- TIMEOUT = 16, no ack → mem_req held exactly 16 cycles, then rsp_err 1, rdata 0. Repeat with the ack on the 16th cycle → err 0 and the data is returned.
- rst_n pulled low in the 2nd BUS cycle → mem_req and busy drop without waiting for a clock, no rsp_valid, req_ready 1. A new LW at 0x0 after release completes normally.
